// File: rtl/dcache_pkg.sv
// Shared constants, FSM state encoding and address field helpers for the
// direct-mapped write-back L1 data cache.
package dcache_pkg;
   localparam int LINES     = 16;
   localparam int ADDR_W    = 32;
   localparam int WORD_W    = 32;
   localparam int WORDS     = 8;
   localparam int LINE_BITS = WORDS * WORD_W;
   localparam int INDEX_W   = $clog2(LINES);
   localparam int OFFSET_W  = 3;
   localparam int TAG_W     = ADDR_W - INDEX_W - 5;

   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILLED} state_t;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1:5+INDEX_W];
   endfunction

   function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
      return a[4+INDEX_W:5];
   endfunction

   function automatic logic [OFFSET_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
      return a[4:2];
   endfunction
endpackage

// File: rtl/dcache_if.sv
// CPU-side access bus and memory-side line transfer bus of the data cache.
// master = cache controller, slave = pipeline/memory environment.
interface dcache_if;
   import dcache_pkg::*;
   logic                 cpu_req_i;
   logic                 cpu_we_i;
   logic [ADDR_W-1:0]    cpu_addr_i;
   logic [WORD_W-1:0]    cpu_wdata_i;
   logic [WORD_W-1:0]    cpu_rdata_o;
   logic                 cpu_stall_o;
   logic                 mem_req_o;
   logic                 mem_we_o;
   logic [ADDR_W-1:0]    mem_addr_o;
   logic [LINE_BITS-1:0] mem_wdata_o;
   logic [LINE_BITS-1:0] mem_rdata_i;
   logic                 mem_ack_i;

   modport master (
      input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
      output cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
   );
   modport slave (
      output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
      input  cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
   );
endinterface

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: asynchronous read, synchronous write,
// synchronous clear of valid/dirty on reset (tags and data are not reset).
module dcache_sram
   import dcache_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [INDEX_W-1:0]   idx,
   output logic                 rd_valid,
   output logic                 rd_dirty,
   output logic [TAG_W-1:0]     rd_tag,
   output logic [LINE_BITS-1:0] rd_line,
   input  logic                 line_we,
   input  logic [TAG_W-1:0]     line_tag,
   input  logic [LINE_BITS-1:0] line_data,
   input  logic                 word_we,
   input  logic [OFFSET_W-1:0]  word_sel,
   input  logic [WORD_W-1:0]    word_data
);
   logic [LINES-1:0]     valid_q;
   logic [LINES-1:0]     dirty_q;
   logic [TAG_W-1:0]     tag_q  [LINES];
   logic [LINE_BITS-1:0] data_q [LINES];

   assign rd_valid = valid_q[idx];
   assign rd_dirty = dirty_q[idx];
   assign rd_tag   = tag_q[idx];
   assign rd_line  = data_q[idx];

   // line state: a refill installs a clean valid line, a store marks it dirty
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (line_we) begin
         valid_q[idx] <= 1'b1;
         dirty_q[idx] <= 1'b0;
      end else if (word_we) begin
         dirty_q[idx] <= 1'b1;
      end
   end

   // payload: whole-line refill or single-word merge
   always_ff @(posedge clk_i) begin
      if (line_we) begin
         tag_q[idx]  <= line_tag;
         data_q[idx] <= line_data;
      end else if (word_we) begin
         data_q[idx][word_sel*WORD_W +: WORD_W] <= word_data;
      end
   end
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Optional hit/miss statistics counters: define DCACHE_STATS_EN.
module dcache_controller
   import dcache_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   dcache_if.master    bus,
   output logic [31:0] hit_cnt_o,
   output logic [31:0] miss_cnt_o
);
   state_t               state_q, state_d;
   logic [TAG_W-1:0]     tag, rd_tag;
   logic [INDEX_W-1:0]   idx;
   logic [OFFSET_W-1:0]  word;
   logic                 rd_valid, rd_dirty, hit;
   logic [LINE_BITS-1:0] rd_line;
   logic                 line_we, word_we;
   logic                 unused_addr_bits;

   assign tag  = addr_tag(bus.cpu_addr_i);
   assign idx  = addr_index(bus.cpu_addr_i);
   assign word = addr_word(bus.cpu_addr_i);
   assign hit  = rd_valid && (rd_tag == tag);
   assign unused_addr_bits = ^bus.cpu_addr_i[1:0];

   dcache_sram u_sram (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .idx       (idx),
      .rd_valid  (rd_valid),
      .rd_dirty  (rd_dirty),
      .rd_tag    (rd_tag),
      .rd_line   (rd_line),
      .line_we   (line_we),
      .line_tag  (tag),
      .line_data (bus.mem_rdata_i),
      .word_we   (word_we),
      .word_sel  (word),
      .word_data (bus.cpu_wdata_i)
   );

   // victim line goes out unchanged; cpu inputs are frozen while stalled
   assign bus.mem_wdata_o = rd_line;
   assign bus.cpu_stall_o = bus.cpu_req_i && (!hit || state_q != IDLE);

   // load data path: selected word of the indexed line, zero when idle
   always_comb begin
      bus.cpu_rdata_o = '0;
      if (bus.cpu_req_i) bus.cpu_rdata_o = rd_line[word*WORD_W +: WORD_W];
   end

   // state register
   always_ff @(posedge clk_i) begin
      if (!rst_i) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // next state, memory handshake and array write strobes
   always_comb begin
      state_d        = state_q;
      bus.mem_req_o  = 1'b0;
      bus.mem_we_o   = 1'b0;
      bus.mem_addr_o = '0;
      line_we        = 1'b0;
      word_we        = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.cpu_req_i) begin
               if (hit)                   word_we = bus.cpu_we_i && rst_i;
               else if (rd_valid && rd_dirty) state_d = WRITEBACK;
               else                       state_d = ALLOCATE;
            end
         end
         WRITEBACK: begin
            bus.mem_req_o  = 1'b1;
            bus.mem_we_o   = 1'b1;
            bus.mem_addr_o = {rd_tag, idx, 5'b0};
            if (bus.mem_ack_i) state_d = ALLOCATE;
         end
         ALLOCATE: begin
            bus.mem_req_o  = 1'b1;
            bus.mem_addr_o = {tag, idx, 5'b0};
            if (bus.mem_ack_i) begin
               line_we = 1'b1;
               state_d = REFILLED;
            end
         end
         REFILLED: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

`ifdef DCACHE_STATS_EN
   logic post_refill_q;

   // statistics: first-lookup hits and miss entries; the re-lookup right
   // after a refill completes the original miss and is not a hit
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         hit_cnt_o     <= '0;
         miss_cnt_o    <= '0;
         post_refill_q <= 1'b0;
      end else begin
         post_refill_q <= (state_q == REFILLED);
         if (state_q == IDLE && bus.cpu_req_i && hit && !post_refill_q)
            hit_cnt_o <= hit_cnt_o + 32'd1;
         if (state_q == IDLE && state_d != IDLE)
            miss_cnt_o <= miss_cnt_o + 32'd1;
      end
   end
`else
   assign hit_cnt_o  = '0;
   assign miss_cnt_o = '0;
`endif
endmodule
